// File: rtl/ks_pipe_addsub.sv
// ks_pipe_addsub: 16-bit Kogge-Stone adder/subtractor split into five
// register stages. st0 holds the bitwise propagate/generate terms. st1..st3
// hold the prefix trees after spans 1, 2 and 4. st4 holds the span-8 result
// and the final sum. A single global stall freezes every stage together.
//
// Prefix vectors are 17 entries wide. Entry 0 is the carry-in position
// (index -1): G = c0 and P = 0. Entry j (1..16) is bit j-1. Because P of
// entry 0 is zero, any group that reaches entry 0 has a zero group-P. A
// plain black combine therefore behaves as the gray combine for those
// groups, and the same cell is used everywhere.
module ks_pipe_addsub (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        SUB,
  input  logic        CIN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] S,
  output logic        COUT,
  output logic        OVF
);

  // (G,P)hi o (G,P)lo -> {G, P}
  function automatic logic [1:0] f_combine(input logic g_hi, input logic p_hi,
                                           input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  logic              w_advance;
  logic [15:0]       w_bx;
  logic              w_c0;
  logic [16:0]       w_g_pre;
  logic [16:0]       w_p_pre;

  // r_g[k]/r_p[k]: prefix state held in stage k (k = 0..3)
  logic [3:0][16:0]  r_g;
  logic [3:0][16:0]  r_p;
  logic [3:0][15:0]  r_pb;      // raw bitwise propagate, carried for the sum
  logic [3:0]        r_v;       // valid bits of st0..st3
  logic [3:0][16:0]  w_g_nxt;   // r_g[k] after combining at span 2^k
  logic [3:0][16:0]  w_p_nxt;

  logic              w_c16;
  logic [15:0]       w_sum;
  logic              w_ovf;
  logic              w_unused_p;

  logic              r_out_valid;
  logic [15:0]       r_s;
  logic              r_cout;
  logic              r_ovf;

  // Global stall: every stage moves when the output slot is empty or draining
  always_comb begin
    w_advance = ~r_out_valid | OUT_READY;
    if (RST) begin
      IN_READY = 1'b0;
    end else begin
      IN_READY = w_advance;
    end
  end

  // Effective operand and carry; the carry-in sits at prefix entry 0
  always_comb begin
    w_bx = B;
    if (SUB) begin
      w_bx = ~B;
    end else begin
      w_bx = B;
    end
    w_c0    = CIN ^ SUB;
    w_g_pre = {A & w_bx, w_c0};
    w_p_pre = {A ^ w_bx, 1'b0};
  end

  // Prefix levels: span 2^k combines entry j with entry j - 2^k
  for (genvar k = 0; k < 4; k++) begin : g_lvl
    for (genvar j = 0; j < 17; j++) begin : g_idx
      if (j >= (1 << k)) begin : g_cmb
        assign {w_g_nxt[k][j], w_p_nxt[k][j]} =
          f_combine(r_g[k][j], r_p[k][j], r_g[k][j-(1<<k)], r_p[k][j-(1<<k)]);
      end else begin : g_pass
        assign w_g_nxt[k][j] = r_g[k][j];
        assign w_p_nxt[k][j] = r_p[k][j];
      end
    end
  end

  // Final carries: entry i after span 8 is c[i]. Entry 16 still misses
  // entry 0, so one last gray combine with c0 gives the carry out.
  always_comb begin
    w_c16 = w_g_nxt[3][16] | (w_p_nxt[3][16] & w_g_nxt[3][0]);
    w_sum = r_pb[3] ^ w_g_nxt[3][15:0];
    w_ovf = w_c16 ^ w_g_nxt[3][15];
  end

  // Group propagates of the last level are dead except at entry 16
  assign w_unused_p = ^w_p_nxt[3][15:0];

  // Pipeline registers: all stages load together on advance, else hold
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_g         <= '0;
      r_p         <= '0;
      r_pb        <= '0;
      r_v         <= 4'b0000;
      r_out_valid <= 1'b0;
      r_s         <= 16'h0000;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_advance) begin
      r_v         <= {r_v[2:0], IN_VALID};
      r_g[0]      <= w_g_pre;
      r_p[0]      <= w_p_pre;
      r_pb[0]     <= w_p_pre[16:1];
      r_g[1]      <= w_g_nxt[0];
      r_p[1]      <= w_p_nxt[0];
      r_pb[1]     <= r_pb[0];
      r_g[2]      <= w_g_nxt[1];
      r_p[2]      <= w_p_nxt[1];
      r_pb[2]     <= r_pb[1];
      r_g[3]      <= w_g_nxt[2];
      r_p[3]      <= w_p_nxt[2];
      r_pb[3]     <= r_pb[2];
      r_out_valid <= r_v[3];
      r_s         <= w_sum;
      r_cout      <= w_c16;
      r_ovf       <= w_ovf;
    end
  end

  assign OUT_VALID = r_out_valid;
  assign S         = r_s;
  assign COUT      = r_cout;
  assign OVF       = r_ovf;

endmodule
